// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source.
// Produces DrawX/DrawY/blank for the renderers, line/frame start pulses,
// and active-low hs/vs sync delayed by SYNC_DELAY cycles so sync edges
// line up with renderer pixel output at the DAC.
// Optional feature macro: VGA_TIMING_FRAME_COUNTER_EN (adds a 16-bit
// frame counter; when undefined frame_count is tied to zero).
module vga_timing_gen #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Refuse to elaborate configurations the 10-bit counters or the
    // delay line cannot represent.
    generate
        if (H_TOTAL > 1024) begin : g_bad_htotal
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_bad_vtotal
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be within 0..4");
        end
    endgenerate

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       hs_raw, vs_raw;

    // hs/vs delay lines; stage 0 is aligned with DrawX/DrawY, the last
    // stage drives the pins.
    logic [SYNC_DELAY:0] hs_pipe_q;
    logic [SYNC_DELAY:0] vs_pipe_q;

    // Next-state counters plus everything derived from them, so all
    // registered outputs describe the same pixel.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) y_d = '0;
            else               y_d = y_q + 10'd1;
        end
        blank_d = (x_d < H_VIS_W) && (y_d < V_VIS_W);
        hs_raw  = !((x_d >= H_SYNC_BEG) && (x_d <= H_SYNC_END));
        vs_raw  = !((y_d >= V_SYNC_BEG) && (y_d <= V_SYNC_END));
        ls_d    = (x_d == '0);
        fs_d    = ls_d && (y_d == '0);
    end

    // Raster counters and pixel-aligned flags. Reset parks the counters
    // on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    // Sync delay line; reset flushes any pulse in flight back to idle-high.
    generate
        if (SYNC_DELAY > 0) begin : g_sync_dly
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= {hs_pipe_q[SYNC_DELAY-1:0], hs_raw};
                    vs_pipe_q <= {vs_pipe_q[SYNC_DELAY-1:0], vs_raw};
                end
            end
        end else begin : g_sync_nodly
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= hs_raw;
                    vs_pipe_q <= vs_raw;
                end
            end
        end
    endgenerate

`ifdef VGA_TIMING_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q;

    // Frame counter advances on the edge that raises frame_start, so the
    // first frame after reset reads 1; wraps naturally at 16 bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)  frame_cnt_q <= '0;
        else if (fs_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'h0000;
`endif

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign hs          = hs_pipe_q[SYNC_DELAY];
    assign vs          = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a shrunken raster (16x8 total) so
// whole frames fit in a short run. Expected outputs come from a closed-form
// model indexed by cycles since reset and flow through a scoreboard queue.
module tb_vga_timing_gen;
    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int D  = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, line_start, frame_start;
    logic [15:0] frame_count;

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_DELAY(D)
    ) dut (
        .vga_clk(clk), .reset_n(rst_n),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_tot = 0, n_bad = 0;
    int t = 0;
    int fc_off = 0;
    logic [63:0] sb[$];
    int tq[$];

    int blank_l0, hs_lo, hs_first, vs_lo, vs_fx, vs_fy, ls_f0;
    int fs_cnt, fs_last, fs_gap, max_x, max_y;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count});
    endfunction

    function automatic logic [63:0] rst_vec();
        logic [9:0] rx = 10'(HT - 1);
        logic [9:0] ry = 10'(VT - 1);
        return 64'({rx, ry, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
    endfunction

    // Expected outputs on cycle tt (tt=0 is the first edge after reset).
    function automatic logic [63:0] exp_vec(input int tt);
        int x = tt % HT;
        int y = (tt / HT) % VT;
        int s = tt - D;
        logic h = 1'b1, v = 1'b1, bl;
        logic [15:0] fc;
        if (s >= 0) begin
            h = !((s % HT) >= HV + HF && (s % HT) <= HV + HF + HS - 1);
            v = !(((s / HT) % VT) >= VV + VF && ((s / HT) % VT) <= VV + VF + VS - 1);
        end
        bl = (x < HV) && (y < VV);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        fc = 16'(fc_off + tt / FR + 1);
`else
        fc = 16'h0000;
`endif
        return 64'({10'(x), 10'(y), bl, h, v, x == 0, (x == 0) && (y == 0), fc});
    endfunction

    task automatic clear_agg();
        blank_l0 = 0; hs_lo = 0; hs_first = -1; vs_lo = 0; vs_fx = -1; vs_fy = -1;
        ls_f0 = 0; fs_cnt = 0; fs_last = -1; fs_gap = -1; max_x = 0; max_y = 0;
    endtask

    // Push expectation at the active edge, pop and compare on the falling edge.
    task automatic run(input int n);
        logic [63:0] e;
        int to;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            sb.push_back(exp_vec(t));
            tq.push_back(t);
            t++;
            @(negedge clk);
            e  = sb.pop_front();
            to = tq.pop_front();
            chk("cyc", dut_vec(), e);
            if (to < HT && blank) blank_l0++;
            if (to < HT && !hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(DrawX);
            end
            if (to < FR && !vs) begin
                vs_lo++;
                if (vs_fx < 0) begin vs_fx = int'(DrawX); vs_fy = int'(DrawY); end
            end
            if (to < FR && line_start) ls_f0++;
            if (frame_start) begin
                if (fs_last >= 0) fs_gap = to - fs_last;
                fs_last = to;
                fs_cnt++;
            end
            if (int'(DrawX) > max_x) max_x = int'(DrawX);
            if (int'(DrawY) > max_y) max_y = int'(DrawY);
        end
    endtask

    initial begin
        bit found;
        // Reset held for 5 cycles.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst", dut_vec(), rst_vec());
        end
        rst_n = 1'b1;
        t = 0; fc_off = 0;
        clear_agg();
        run(2 * FR);
        chk("blank_line", 64'(blank_l0), 64'(HV));
        chk("hs_width", 64'(hs_lo), 64'(HS));
        chk("hs_first_x", 64'(hs_first), 64'(HV + HF + D));
        chk("vs_width", 64'(vs_lo), 64'(VS * HT));
        chk("vs_first_y", 64'(vs_fy), 64'(VV + VF));
        chk("vs_first_x", 64'(vs_fx), 64'(D));
        chk("ls_per_frame", 64'(ls_f0), 64'(VT));
        chk("fs_count", 64'(fs_cnt), 64'd2);
        chk("fs_gap", 64'(fs_gap), 64'(FR));
        chk("max_x", 64'(max_x), 64'(HT - 1));
        chk("max_y", 64'(max_y), 64'(VT - 1));

`ifdef VGA_TIMING_FRAME_COUNTER_EN
        // Third frame, then preset the counter so the fourth frame wraps it.
        run(FR);
        chk("fc_3", 64'(frame_count), 64'd3);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        fc_off = 16'hFFFF - 3;
        run(1);
        chk("fc_wrap", 64'(frame_count), 64'h0000);
`else
        chk("fc_zero", 64'(frame_count), 64'h0000);
`endif

        // Find a cycle mid-hsync, then reset asynchronously.
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            run(1);
            if (!hs && DrawX == 10'(HV + HF + D + 1)) found = 1'b1;
        end
        chk("hs_seek", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", dut_vec(), rst_vec());
        @(negedge clk);
        chk("rst_hold", dut_vec(), rst_vec());
        rst_n = 1'b1;
        t = 0; fc_off = 0;
        sb.delete(); tq.delete();
        clear_agg();
        run(HT + 2);
        chk("re_hs_first_x", 64'(hs_first), 64'(HV + HF + D));
        chk("re_hs_width", 64'(hs_lo), 64'(HS));
        chk("re_fs", 64'(fs_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
